// File: rtl/universal_subtractor_seq_if.sv
// Operand/result handshake bundle for the chunked subtractor.
// The master drives operands and accepts results; the slave is the subtractor.
interface universal_subtractor_seq_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [1:0]       op;
   logic             bin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] r;
   logic             borrow;
   logic             ovf;

   modport master (
      output in_valid, a, b, op, bin, out_ready,
      input  in_ready, out_valid, r, borrow, ovf
   );

   modport slave (
      input  in_valid, a, b, op, bin, out_ready,
      output in_ready, out_valid, r, borrow, ovf
   );
endinterface

// File: rtl/universal_subtractor_seq.sv
// Multi-cycle subtractor: CHUNK bits per clock with a registered borrow chain,
// modes A-B, A-B-bin, B-A and |A-B| (negative results re-negated chunk-wise).
module universal_subtractor_seq #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   universal_subtractor_seq_if.slave bus
);
   localparam int N  = WIDTH / CHUNK;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, RUN, NEG, DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] x_q, x_d, y_q, y_d, r_q, r_d;
   logic [1:0]       op_q, op_d;
   logic             chain_q, chain_d;
   logic             borrow_q, borrow_d, ovf_q, ovf_d, ovalid_q, ovalid_d;
   logic [CHUNK:0]   diff, neg;
   logic             last;
   int               base;

   // chain_q carries the borrow in RUN and the increment carry in NEG
   always_comb begin
      base = int'(cnt_q) * CHUNK;
      last = (cnt_q == CW'(N - 1));
      diff = {1'b0, x_q[base +: CHUNK]} - {1'b0, y_q[base +: CHUNK]}
             - (CHUNK+1)'(chain_q);
      neg  = {1'b0, ~r_q[base +: CHUNK]} + (CHUNK+1)'(chain_q);
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      x_d      = x_q;
      y_d      = y_q;
      r_d      = r_q;
      op_d     = op_q;
      chain_d  = chain_q;
      borrow_d = borrow_q;
      ovf_d    = ovf_q;
      ovalid_d = ovalid_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               x_d     = (bus.op == 2'b10) ? bus.b : bus.a;
               y_d     = (bus.op == 2'b10) ? bus.a : bus.b;
               op_d    = bus.op;
               chain_d = (bus.op == 2'b01) ? bus.bin : 1'b0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            r_d[base +: CHUNK] = diff[CHUNK-1:0];
            chain_d = diff[CHUNK];
            cnt_d   = cnt_q + CW'(1);
            if (last) begin
               cnt_d    = '0;
               borrow_d = diff[CHUNK];
               ovf_d    = (op_q != 2'b11) && (x_q[WIDTH-1] != y_q[WIDTH-1])
                          && (diff[CHUNK-1] != x_q[WIDTH-1]);
               if (op_q == 2'b11 && diff[CHUNK]) begin
                  chain_d = 1'b1;
                  state_d = NEG;
               end else begin
                  ovalid_d = 1'b1;
                  state_d  = DONE;
               end
            end
         end
         NEG: begin
            r_d[base +: CHUNK] = neg[CHUNK-1:0];
            chain_d = neg[CHUNK];
            cnt_d   = cnt_q + CW'(1);
            if (last) begin
               cnt_d    = '0;
               ovalid_d = 1'b1;
               state_d  = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               ovalid_d = 1'b0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         x_q      <= '0;
         y_q      <= '0;
         r_q      <= '0;
         op_q     <= 2'b00;
         chain_q  <= 1'b0;
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
         ovalid_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         x_q      <= x_d;
         y_q      <= y_d;
         r_q      <= r_d;
         op_q     <= op_d;
         chain_q  <= chain_d;
         borrow_q <= borrow_d;
         ovf_q    <= ovf_d;
         ovalid_q <= ovalid_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = ovalid_q;
   assign bus.r         = r_q;
   assign bus.borrow    = borrow_q;
   assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_universal_subtractor_seq.sv
// Bench for universal_subtractor_seq: a 16/4 and an 8/8 instance share clock and
// reset; sel picks which one the directed and random steps drive and observe.
module tb_universal_subtractor_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   universal_subtractor_seq_if #(.WIDTH(16)) bus16 ();
   universal_subtractor_seq_if #(.WIDTH(8))  bus8 ();

   universal_subtractor_seq #(.WIDTH(16), .CHUNK(4)) dut16 (
      .clk(clk), .rst_n(rst_n), .bus(bus16.slave));
   universal_subtractor_seq #(.WIDTH(8), .CHUNK(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .bus(bus8.slave));

   int   n_chk = 0;
   int   n_pass = 0;
   int   n_fail = 0;
   logic sel = 1'b0;

   logic        o_iready, o_ovalid, o_bo, o_ovf;
   logic [15:0] o_r;
   assign o_iready = sel ? bus8.in_ready  : bus16.in_ready;
   assign o_ovalid = sel ? bus8.out_valid : bus16.out_valid;
   assign o_bo     = sel ? bus8.borrow    : bus16.borrow;
   assign o_ovf    = sel ? bus8.ovf       : bus16.ovf;
   assign o_r      = sel ? {8'h00, bus8.r} : bus16.r;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: integer arithmetic on the operand values, signed overflow from
   // the mathematically exact signed difference.
   task automatic model(input int w, input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] op, input logic bin,
                        output logic [15:0] r, output logic bo, output logic ovf);
      longint half = longint'(1) << (w - 1);
      longint mask = (longint'(1) << w) - 1;
      longint ua = longint'(a) & mask;
      longint ub = longint'(b) & mask;
      longint sa = (ua >= half) ? ua - 2 * half : ua;
      longint sb = (ub >= half) ? ub - 2 * half : ub;
      longint d, sd;
      case (op)
         2'b00:   begin d = ua - ub;       sd = sa - sb;       end
         2'b01:   begin d = ua - ub - bin; sd = sa - sb - bin; end
         2'b10:   begin d = ub - ua;       sd = sb - sa;       end
         default: begin d = (ua >= ub) ? ua - ub : ub - ua; sd = 0; end
      endcase
      r   = 16'(d & mask);
      bo  = (op == 2'b11) ? (ua < ub) : (d < 0);
      ovf = (op != 2'b11) && ((sd < -half) || (sd >= half));
   endtask

   task automatic drive_in(input logic v, input logic [15:0] a, input logic [15:0] b,
                           input logic [1:0] op, input logic bin);
      bus16.in_valid = v & ~sel;
      bus8.in_valid  = v & sel;
      bus16.a = a;      bus8.a = a[7:0];
      bus16.b = b;      bus8.b = b[7:0];
      bus16.op = op;    bus8.op = op;
      bus16.bin = bin;  bus8.bin = bin;
   endtask

   task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] op, input logic bin,
                        input int hold, input bit noise);
      logic [15:0] er;
      logic        ebo, eovf;
      int          n, lat, explat;
      n = sel ? 1 : 4;
      model(sel ? 8 : 16, a, b, op, bin, er, ebo, eovf);
      explat = (op == 2'b11 && ebo) ? 2 * n : n;
      @(negedge clk);
      check({tag, " in_ready"}, o_iready, 1);
      drive_in(1'b1, a, b, op, bin);
      @(posedge clk);
      @(negedge clk);
      drive_in(1'b0, a, b, op, bin);
      lat = 0;
      while (!o_ovalid && lat < 100) begin
         if (noise) drive_in(1'b1, 16'($urandom), 16'($urandom), 2'($urandom), 1'($urandom));
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      check({tag, " latency"}, lat, explat);
      check({tag, " out_valid"}, o_ovalid, 1);
      check({tag, " r"}, o_r, er);
      check({tag, " borrow"}, o_bo, ebo);
      check({tag, " ovf"}, o_ovf, eovf);
      for (int i = 0; i < hold; i++) begin
         if (noise) drive_in(1'b1, 16'($urandom), 16'($urandom), 2'($urandom), 1'($urandom));
         @(posedge clk);
         @(negedge clk);
         check({tag, " hold out_valid"}, o_ovalid, 1);
         check({tag, " hold r"}, o_r, er);
         check({tag, " hold borrow"}, o_bo, ebo);
         check({tag, " hold ovf"}, o_ovf, eovf);
         check({tag, " hold in_ready"}, o_iready, 0);
      end
      drive_in(1'b0, a, b, op, bin);
      bus16.out_ready = 1'b1;
      bus8.out_ready  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus16.out_ready = 1'b0;
      bus8.out_ready  = 1'b0;
      check({tag, " consumed out_valid"}, o_ovalid, 0);
      check({tag, " consumed in_ready"}, o_iready, 1);
   endtask

   initial begin
      logic [15:0] da [9] = '{16'h1234, 16'h0000, 16'h0005, 16'h0005, 16'h0003,
                              16'h8000, 16'h0003, 16'h0010, 16'h1234};
      logic [15:0] db [9] = '{16'h0234, 16'h0001, 16'h0003, 16'h0003, 16'h0005,
                              16'h0001, 16'h0010, 16'h0003, 16'h5678};
      logic [1:0]  dop [9] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b11, 2'b11, 2'b01};
      logic        dbin [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

      drive_in(1'b0, 16'h0, 16'h0, 2'b00, 1'b0);
      bus16.out_ready = 1'b0;
      bus8.out_ready  = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         check("reset in_ready", o_iready, 1);
         check("reset out_valid", o_ovalid, 0);
         check("reset r", o_r, 0);
         check("reset borrow", o_bo, 0);
         check("reset ovf", o_ovf, 0);
      end
      rst_n = 1'b1;

      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         for (int i = 0; i < 8; i++)
            do_op($sformatf("w%0d dir%0d", sel ? 8 : 16, i), da[i], db[i], dop[i], dbin[i], 0, 1'b0);
         do_op($sformatf("w%0d backpressure", sel ? 8 : 16), da[8], db[8], dop[8], dbin[8], 5, 1'b1);

         // async reset mid-RUN discards the operation
         @(negedge clk);
         drive_in(1'b1, 16'h1234, 16'h0234, 2'b00, 1'b0);
         @(posedge clk);
         @(negedge clk);
         drive_in(1'b0, 16'h0, 16'h0, 2'b00, 1'b0);
         if (!sel) begin
            @(posedge clk);
            @(negedge clk);
         end
         rst_n = 1'b0;
         #1;
         check("midrun reset out_valid", o_ovalid, 0);
         check("midrun reset r", o_r, 0);
         check("midrun reset in_ready", o_iready, 1);
         @(posedge clk);
         @(negedge clk);
         rst_n = 1'b1;
         do_op("after reset ffff-ffff", 16'hFFFF, 16'hFFFF, 2'b00, 1'b0, 0, 1'b0);

         for (int i = 0; i < 25; i++)
            do_op($sformatf("w%0d rnd%0d", sel ? 8 : 16, i), 16'($urandom), 16'($urandom),
                  2'($urandom_range(3, 0)), 1'($urandom), (i % 5 == 0) ? 2 : 0, (i % 3 == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
